// File: rtl/mips_mc_controller.sv
// Moore control FSM for the multicycle MIPS datapath, which feeds aluop to the ALU decoder.
// Optional feature: define MC_CTRL_BNE_EN to add the BNE state (S12) and its pcen term.
module mips_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_pcwrite;
  logic   w_branch;
`ifdef MC_CTRL_BNE_EN
  logic   w_branchne;
`endif

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // NOTE: every output gets a default before the case, so no state can infer a latch.
  always_comb begin
    w_next    = S_FETCH;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
`ifdef MC_CTRL_BNE_EN
    w_branchne = 1'b0;
`endif
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    iord      = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    aluop     = 2'b00;
    case (r_state)
      S_FETCH: begin
        irwrite   = 1'b1;
        w_pcwrite = 1'b1;
        alusrcb   = 2'b01;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       w_next = S_BNE;
`endif
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // An opcode that is neither lw nor sw here aborts without touching memory.
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNE: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        w_branchne = 1'b1;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

`ifdef MC_CTRL_BNE_EN
  assign pcen = w_pcwrite | (w_branch & zero) | (w_branchne & ~zero);
`else
  assign pcen = w_pcwrite | (w_branch & zero);
`endif

  assign state = r_state;

endmodule
